// File: rtl/div_issue_ctrl_pkg.sv
// div_ctrl_pkg: shared types and constants for the divide issue controller.
//   div_state_e   - controller state encoding (IDLE, RUN, DRAIN, DONE)
//   DIV0_QUOT     - quotient returned for a zero divisor (all-ones)
//   cache_entry_t - one-entry last-operand result cache
//   div0_result() - result of an op whose divisor is zero
package div_ctrl_pkg;

  // Width of the attached iterative divider core. The cache entry is sized
  // from this, so the controller's DATA_W has to equal it.
  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  localparam logic [DIV_DATA_W-1:0] DIV0_QUOT = '1;

  typedef struct packed {
    logic                  valid;
    logic [DIV_DATA_W-1:0] x;
    logic [DIV_DATA_W-1:0] y;
    logic                  sgn;
    logic [DIV_DATA_W-1:0] q;
    logic [DIV_DATA_W-1:0] r;
  } cache_entry_t;

  // Divide by zero: quotient is all-ones, remainder is the dividend.
  function automatic logic [DIV_DATA_W-1:0] div0_result(input logic            is_mod,
                                                        input logic [DIV_DATA_W-1:0] x);
    return is_mod ? x : DIV0_QUOT;
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: request, result and divider-core signals of the divide
// issue controller.
//   req_*   : EX-stage request (valid/ready, mod, signed, x, y)
//   flush   : pipeline cancel
//   res_*   : result handshake and data
//   busy    : controller not idle
//   div_*   : launch/operands to and results from the iterative divider
// Modports:
//   slave  - the controller
//   master - the surroundings (pipeline + divider core)
interface div_issue_ctrl_if #(
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_mod;
  logic              req_signed;
  logic [DATA_W-1:0] req_x;
  logic [DATA_W-1:0] req_y;
  logic              flush;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              busy;
  logic              div_start;
  logic              div_signed;
  logic [DATA_W-1:0] div_x;
  logic [DATA_W-1:0] div_y;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] div_r;
  logic              div_complete;

  modport slave (
    input  req_valid, req_mod, req_signed, req_x, req_y, flush,
    input  res_ready, div_q, div_r, div_complete,
    output req_ready, res_valid, res_data, busy,
    output div_start, div_signed, div_x, div_y
  );

  modport master (
    output req_valid, req_mod, req_signed, req_x, req_y, flush,
    output res_ready, div_q, div_r, div_complete,
    input  req_ready, res_valid, res_data, busy,
    input  div_start, div_signed, div_x, div_y
  );

endinterface

// File: rtl/div_issue_ctrl_cache.sv
// div_result_cache: single-entry cache of the last divider result.
// Ports:
//   clk, resetn          clock, async active-low reset (entry invalid)
//   lk_x_i/lk_y_i/lk_signed_i  lookup operands (from the incoming request)
//   hit_o                lookup matches the valid entry
//   hit_quot_o/hit_rem_o cached quotient / remainder
//   ld_en_i              load the entry with ld_* and mark it valid
//   ld_*_i               operands and divider results to store
// With CACHE_EN = 0 no entry exists and hit_o is tied low.
module div_result_cache
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W   = DIV_DATA_W,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] lk_x_i,
  input  logic [DATA_W-1:0] lk_y_i,
  input  logic              lk_signed_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_quot_o,
  output logic [DATA_W-1:0] hit_rem_o,
  input  logic              ld_en_i,
  input  logic [DATA_W-1:0] ld_x_i,
  input  logic [DATA_W-1:0] ld_y_i,
  input  logic              ld_signed_i,
  input  logic [DATA_W-1:0] ld_q_i,
  input  logic [DATA_W-1:0] ld_r_i
);

  if (CACHE_EN) begin : g_cache
    cache_entry_t entry_q;
    cache_entry_t entry_d;

    always_comb begin
      entry_d = entry_q;
      if (ld_en_i) begin
        entry_d.valid = 1'b1;
        entry_d.x     = ld_x_i;
        entry_d.y     = ld_y_i;
        entry_d.sgn   = ld_signed_i;
        entry_d.q     = ld_q_i;
        entry_d.r     = ld_r_i;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    // The mod bit is not part of the key: one divider run yields both
    // quotient and remainder.
    assign hit_o      = entry_q.valid && (entry_q.x == lk_x_i) &&
                        (entry_q.y == lk_y_i) && (entry_q.sgn == lk_signed_i);
    assign hit_quot_o = entry_q.q;
    assign hit_rem_o  = entry_q.r;
  end else begin : g_nocache
    logic unused_cache_in;
    assign unused_cache_in = ^{clk, resetn, lk_x_i, lk_y_i, lk_signed_i, ld_en_i,
                               ld_x_i, ld_y_i, ld_signed_i, ld_q_i, ld_r_i};
    assign hit_o      = 1'b0;
    assign hit_quot_o = '0;
    assign hit_rem_o  = '0;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequencer between the EX-stage divide request path and the
// iterative divider core. Takes one div/mod (signed or unsigned) op at a
// time, answers it from the last-result cache or the divide-by-zero rule,
// or launches the divider, then presents quotient or remainder with
// valid/ready. Flushes kill the op, including while the divider runs.
// Ports:
//   clk     core clock, shared with the divider
//   resetn  async active-low reset (divider reset is ~resetn at the parent)
//   bus     div_issue_ctrl_if.slave: request, flush, result, busy and the
//           divider launch/operand/result signals
//
// state | meaning
// IDLE  | req_ready high; accept op, resolve hit / y==0 / launch
// RUN   | divider running; div_start high in the first cycle only
// DRAIN | flushed op still in the divider; wait for complete, no result
// DONE  | res_valid high until res_ready or flush
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W   = DIV_DATA_W,
  parameter bit CACHE_EN = 1'b1
) (
  input logic             clk,
  input logic             resetn,
  div_issue_ctrl_if.slave bus
);

  div_state_e        state_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic              div_start_q;
  logic              div_signed_q;
  logic [DATA_W-1:0] div_x_q;
  logic [DATA_W-1:0] div_y_q;
  logic              mod_q;

  logic              cache_hit;
  logic              cache_ld;
  logic [DATA_W-1:0] hit_quot;
  logic [DATA_W-1:0] hit_rem;

  // A flushed op still fills the cache when the divider finishes, so the
  // work is not wasted if the same operands are reissued after the flush.
  assign cache_ld = bus.div_complete && ((state_q == RUN) || (state_q == DRAIN));

  div_result_cache #(
    .DATA_W   (DATA_W),
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk         (clk),
    .resetn      (resetn),
    .lk_x_i      (bus.req_x),
    .lk_y_i      (bus.req_y),
    .lk_signed_i (bus.req_signed),
    .hit_o       (cache_hit),
    .hit_quot_o  (hit_quot),
    .hit_rem_o   (hit_rem),
    .ld_en_i     (cache_ld),
    .ld_x_i      (div_x_q),
    .ld_y_i      (div_y_q),
    .ld_signed_i (div_signed_q),
    .ld_q_i      (bus.div_q),
    .ld_r_i      (bus.div_r)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      div_start_q  <= 1'b0;
      div_signed_q <= 1'b0;
      div_x_q      <= '0;
      div_y_q      <= '0;
      mod_q        <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            mod_q <= bus.req_mod;
            if (cache_hit) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= bus.req_mod ? hit_rem : hit_quot;
            end else if (bus.req_y == '0) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= div0_result(bus.req_mod, bus.req_x);
            end else begin
              // Operands are only reloaded on launch so they stay stable
              // through RUN/DRAIN and double as the cache load key.
              state_q      <= RUN;
              div_start_q  <= 1'b1;
              div_x_q      <= bus.req_x;
              div_y_q      <= bus.req_y;
              div_signed_q <= bus.req_signed;
            end
          end
        end
        RUN: begin
          if (bus.div_complete) begin
            if (bus.flush) begin
              state_q <= IDLE;
            end else begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= mod_q ? bus.div_r : bus.div_q;
            end
          end else if (bus.flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.div_complete) begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          // flush and res_ready both retire the result; either way DONE ends.
          if (bus.flush || bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.div_start  = div_start_q;
  assign bus.div_signed = div_signed_q;
  assign bus.div_x      = div_x_q;
  assign bus.div_y      = div_y_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  div_issue_ctrl_if #(.DATA_W(32)) bus ();

  div_issue_ctrl #(
    .DATA_W   (32),
    .CACHE_EN (1'b1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int div_lat  = 4;

  // Abstract view of the result cache: operands of the last divider run.
  bit          mc_valid = 1'b0;
  logic [31:0] mc_x = '0;
  logic [31:0] mc_y = '0;
  bit          mc_s = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Architectural divide result (RISC-V M rules).
  function automatic logic [31:0] ref_res(input bit mod, input bit sgn,
                                          input logic [31:0] x, input logic [31:0] y);
    int xs, ys;
    if (y == 32'd0) return mod ? x : 32'hFFFF_FFFF;
    if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return mod ? 32'd0 : x;
      xs = int'(x);
      ys = int'(y);
      return mod ? 32'(xs % ys) : 32'(xs / ys);
    end
    return mod ? (x % y) : (x / y);
  endfunction

  // Divider core: sees div_start, answers div_lat cycles later.
  initial begin
    int cnt;
    bit pend;
    logic [31:0] cx, cy;
    bit cs;
    cnt = 0; pend = 1'b0; cx = '0; cy = '0; cs = 1'b0;
    bus.div_complete = 1'b0;
    bus.div_q = '0;
    bus.div_r = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.div_complete = 1'b0;
      if (!resetn) begin
        pend = 1'b0;
      end else begin
        if (bus.div_start) n_starts++;
        if (pend) begin
          cnt--;
          if (cnt <= 0) begin
            bus.div_complete = 1'b1;
            bus.div_q = ref_res(1'b0, cs, cx, cy);
            bus.div_r = ref_res(1'b1, cs, cx, cy);
            pend = 1'b0;
          end
        end else if (bus.div_start) begin
          pend = 1'b1;
          cnt  = div_lat;
          cx   = bus.div_x;
          cy   = bus.div_y;
          cs   = bus.div_signed;
        end
      end
    end
  end

  task automatic run_op(input bit mod, input bit sgn, input logic [31:0] x, input logic [31:0] y,
                        input int flush_run, input int bp, input bit done_flush);
    bit launch, seen, bad;
    logic [31:0] exp;
    int s0;
    launch = (y != 32'd0) && !(mc_valid && mc_x == x && mc_y == y && mc_s == sgn);
    exp = ref_res(mod, sgn, x, y);
    s0 = n_starts;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_mod    = mod;
    bus.req_signed = sgn;
    bus.req_x      = x;
    bus.req_y      = y;
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!launch) chk("fast_valid", {31'd0, bus.res_valid}, 32'd1);
    if (launch && flush_run >= 0) begin
      repeat (flush_run) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      seen = 1'b0;
      bad  = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (!bus.busy) begin
          seen = 1'b1;
          break;
        end
        if (bus.req_ready || bus.res_valid) bad = 1'b1;
      end
      chk("drain_done", {31'd0, seen}, 32'd1);
      chk("drain_quiet", {31'd0, bad}, 32'd0);
      chk("drain_no_res", {31'd0, bus.res_valid}, 32'd0);
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (bus.res_valid) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("res_seen", {31'd0, seen}, 32'd1);
      chk("res_data", bus.res_data, exp);
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_data", bus.res_data, exp);
        chk("bp_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      @(negedge clk);
      bus.res_ready = 1'b1;
      bus.flush     = done_flush;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      bus.flush     = 1'b0;
      chk("hs_valid_clr", {31'd0, bus.res_valid}, 32'd0);
      chk("hs_idle", {31'd0, bus.busy}, 32'd0);
    end
    chk("start_count", 32'(n_starts - s0), {31'd0, launch});
    if (launch) begin
      mc_valid = 1'b1;
      mc_x = x;
      mc_y = y;
      mc_s = sgn;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_div_start", {31'd0, bus.div_start}, 32'd0);
    chk("rst_div_x", bus.div_x, 32'd0);
    chk("rst_div_y", bus.div_y, 32'd0);
    chk("rst_div_signed", {31'd0, bus.div_signed}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, sel;
    bit rm, rs;
    logic [31:0] rx, ry;
    bus.req_valid  = 1'b0;
    bus.req_mod    = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.flush      = 1'b0;
    bus.res_ready  = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state();
    resetn = 1'b1;

    // Unsigned, then cache hit on mod
    div_lat = 6;
    run_op(1'b0, 1'b0, 32'd100, 32'd7, -1, 0, 1'b0);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, -1, 0, 1'b0);

    // Signed, hit on mod, miss on unsigned
    div_lat = 5;
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, 0, 1'b0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, 0, 1'b0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, -1, 1, 1'b0);

    // Divide by zero leaves the cache alone
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1, 0, 1'b0);
    run_op(1'b1, 1'b1, 32'd5, 32'd0, -1, 0, 1'b0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, -1, 0, 1'b0);

    // Flush mid-RUN, then the drained result is a cache hit
    div_lat = 9;
    run_op(1'b0, 1'b0, 32'd1000, 32'd3, 2, 0, 1'b0);
    run_op(1'b1, 1'b0, 32'd1000, 32'd3, -1, 0, 1'b0);

    // Backpressure, then flush together with res_ready
    div_lat = 4;
    run_op(1'b0, 1'b0, 32'd50, 32'd5, -1, 5, 1'b1);

    // Request with flush in IDLE is dropped
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_x = 32'd123;
    bus.req_y = 32'd4;
    bus.req_signed = 1'b0;
    bus.req_mod = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_flush_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("idle_flush_start", {31'd0, bus.div_start}, 32'd0);

    // Signed overflow goes through the divider unmodified
    div_lat = 3;
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 1'b0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 1'b0);

    // Asynchronous reset in the middle of RUN
    div_lat = 20;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_mod = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_x = 32'd77;
    bus.req_y = 32'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk_reset_state();
    mc_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    div_lat = 5;
    run_op(1'b0, 1'b0, 32'd77, 32'd7, -1, 0, 1'b0);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, -1, 0, 1'b0);

    // Randomized ops with operand reuse to exercise hits and misses
    for (int n = 0; n < 60; n++) begin
      rm = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 7));
      case (sel)
        0, 1, 2: begin rx = mc_x; ry = mc_y; rs = (sel == 2) ? rs : mc_s; end
        3:       begin rx = $urandom; ry = 32'd0; end
        4:       begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        5:       begin rx = $urandom; ry = $urandom; end
        default: begin rx = $urandom_range(0, 5000); ry = $urandom_range(1, 50); end
      endcase
      fr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      div_lat = (fr < 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(fr + 3, fr + 10));
      run_op(rm, rs, rx, ry, fr, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
